apb_mem_slave: RTL and testbench
================================

# apb_mem_slave

Parametrised APB completer with word-addressed memory. It succeeds the fixed 9-bit-address, 8-bit-data APB signal set with configurable address and data widths, depth and wait states. It adds an error response (`pslverr`) and, optionally, byte strobes. It is the standard memory-backed endpoint for the APB verification environment and for small register/SRAM islands on the peripheral bus.

## Interface
Parameters:
- `ADDR_W`, default 9: width of `paddr`.
- `DATA_W`, default 32: width of `pwdata`/`prdata`. Must be a multiple of 8.
- `DEPTH`, default 512: number of words. Must satisfy `DEPTH <= 2**ADDR_W`.
- `WAIT_CYCLES`, default 0: wait states inserted in every access phase. Range 0..15.

Ports:
- `clk`, in, 1: clock, rising edge.
- `prst`, in, 1: reset, asynchronous, active-high.
- `psel`, in, 1: select.
- `pen`, in, 1: enable, marks the access phase.
- `pwrite`, in, 1: 1 = write, 0 = read.
- `paddr`, in, `ADDR_W`: word address.
- `pwdata`, in, `DATA_W`: write data.
- `pstrb`, in, `DATA_W/8`: byte write strobes. Present only with `APB_SLV_PSTRB_EN`.
- `prdata`, out, `DATA_W`: read data. Valid only when `pready` = 1 on a read.
- `pready`, out, 1: transfer completes this cycle.
- `pslverr`, out, 1: error on the completing transfer. Valid only when `pready` = 1.

## Operation
- FSM states:
  - `IDLE`: `psel`=1, `pen`=0 → `SETUP`. Any other input combination → stay in `IDLE`. `pen`=1 seen in `IDLE` is a protocol violation and is ignored.
  - `SETUP`: latch `paddr`, `pwrite`, `pwdata` (and `pstrb`). Load wait counter with `WAIT_CYCLES`. Next cycle, `psel`=1 and `pen`=1 → `ACCESS`, otherwise → `IDLE` with no side effects.
  - `ACCESS`: while counter ≠ 0, `pready`=0 and decrement.
    - When counter = 0, `pready`=1 and the transfer completes, then → `IDLE`.
    - `psel` or `pen` dropping in `ACCESS` aborts the transfer → `IDLE`. No write occurs and `pready` stays 0.
- Error: latched address ≥ `DEPTH` → `pslverr`=1 on the completing cycle. A write is discarded and `prdata` = 0.
- Write: commits at the rising edge that ends the `pready`=1 cycle, using the latched address and data.
- Read: `prdata` = `mem[addr]`, driven for the completing cycle. `prdata` is 0 in every other cycle.
- Read-after-write to the same address in the next transfer returns the new data.
- Memory contents are not reset. After reset, reads of unwritten words return X in simulation.

## Timing
- Reset values: `pready`=0, `pslverr`=0, `prdata`=0, FSM = `IDLE`, counter = 0.
- Asserting `prst` mid-transfer aborts it and no write occurs.
- `pready`, `pslverr` and `prdata` are decoded from registered state only. They have no combinational path from `psel`, `pen` or `paddr`.
- Transfer length from the setup cycle is 2 + `WAIT_CYCLES` cycles. With `WAIT_CYCLES`=0, `pready`=1 in the first access cycle.
- Back-to-back transfers: a new setup phase may start in the cycle after `pready`=1. Minimum period is 2 + `WAIT_CYCLES`.
- Address, data and direction changes by the requester during `ACCESS` are ignored. The values latched in `SETUP` are used.

## Configuration
- `APB_SLV_PSTRB_EN` defined:
  - The `pstrb` port exists.
  - A write updates only the bytes whose strobe is 1. `pstrb`=0 is a legal no-op write.
  - Reads ignore `pstrb`.
- `APB_SLV_PSTRB_EN` undefined: the `pstrb` port is absent and every write updates the full word.

## Structure
- Package `apb_pkg` holds:
  - the FSM state enum (`IDLE`, `SETUP`, `ACCESS`);
  - the localparam for the wait-counter width (4);
  - the parameter legality checks: `DATA_W%8==0`, `DEPTH<=2**ADDR_W`, `WAIT_CYCLES<=15`.
- One sub-module, `apb_slv_mem`: synchronous single-port `DEPTH`×`DATA_W` array.
  - Per-byte write enables.
  - Combinational read, so `prdata` is valid in the completing cycle.

## Test plan
- `WAIT_CYCLES`=0: write 0xDEADBEEF to addr 5, then read addr 5 → each transfer has `pready` 1 in its 2nd cycle, `pslverr`=0, read returns 0xDEADBEEF.
- `WAIT_CYCLES`=3: read addr 7 after writing 0x11 → `pready` low for 3 access cycles, high on the 4th, `prdata`=0x11 only in that cycle.
- `DEPTH`=256, `ADDR_W`=9: write 0xAA to addr 300, then read addr 300 → both complete with `pslverr`=1 and read `prdata`=0. Addr 300 mod 256 = 44 is unchanged.
- Abort: setup a write of 0x55 to addr 2, drop `psel` in the access phase → FSM returns to `IDLE`, `pready` never 1, addr 2 keeps its old value. Same check with `prst` asserted mid-access.
- With `APB_SLV_PSTRB_EN`: write 0xFFFFFFFF, then write 0x12345678 with `pstrb`=4'b0101 → read returns 0xFF34FF78.
- Back-to-back: 8 consecutive writes then 8 reads with no idle cycles → all data matches and every transfer takes exactly 2 + `WAIT_CYCLES` cycles.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB memory completer: FSM state encoding,
// wait-counter width and parameter legality helpers.
package apb_pkg;

  // Bus-facing FSM states of the completer.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Width of the wait-state counter; bounds WAIT_CYCLES to 0..15.
  localparam int unsigned WAIT_W   = 4;
  localparam int unsigned WAIT_MAX = (1 << WAIT_W) - 1;

  // Data bus must be a whole number of bytes.
  function automatic bit data_w_ok(input int unsigned data_w);
    return (data_w != 0) && (data_w % 8 == 0);
  endfunction

  // Every word must be reachable through the address bus.
  function automatic bit depth_ok(input int unsigned depth, input int unsigned addr_w);
    return (depth >= 1) && (longint'(depth) <= (longint'(1) << addr_w));
  endfunction

  // Wait states must fit in the wait counter.
  function automatic bit wait_ok(input int unsigned wait_cycles);
    return wait_cycles <= WAIT_MAX;
  endfunction

  // Index width of the memory array (at least one bit).
  function automatic int unsigned mem_aw(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_slv_mem.sv
// Single-port DEPTH x DATA_W storage with per-byte write enables and a
// combinational read port, so read data is available in the same cycle the
// address is presented.
module apb_slv_mem
  import apb_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 512,
  localparam int AW     = mem_aw(DEPTH),
  localparam int STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [STRB_W-1:0] be_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // Byte-masked write on the rising edge.
  // NOTE: the array has no reset branch on purpose; resetting a memory turns
  // it into a sea of flops and prevents mapping onto an SRAM macro.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/apb_mem_slave.sv
// APB completer backed by a word-addressed memory, with configurable
// address/data width, depth and wait states, plus an out-of-range error
// response. Define APB_SLV_PSTRB_EN to add the pstrb port and byte-masked
// writes; without it every write updates the full word.
//
// Timing: the setup phase is captured at the edge that ends it, so pready,
// pslverr and prdata come purely from registered state. With WAIT_CYCLES=0
// pready is already high in the first access cycle.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                clk,
  input  logic                prst,
  input  logic                psel,
  input  logic                pen,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  output logic [DATA_W-1:0]   prdata,
  output logic                pready,
  output logic                pslverr
);

  localparam int                STRB_W    = DATA_W / 8;
  localparam int                MEM_AW    = mem_aw(DEPTH);
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_CYCLES);

  // Reject illegal parameter sets at elaboration.
  if (!data_w_ok(DATA_W)) begin : g_bad_data_w
    $error("apb_mem_slave: DATA_W must be a non-zero multiple of 8");
  end
  if (!depth_ok(DEPTH, ADDR_W)) begin : g_bad_depth
    $error("apb_mem_slave: DEPTH must be 1..2**ADDR_W");
  end
  if (!wait_ok(WAIT_CYCLES)) begin : g_bad_wait
    $error("apb_mem_slave: WAIT_CYCLES must be 0..15");
  end

  // Address lies outside the implemented words.
  function automatic logic out_of_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} >= (ADDR_W+1)'(DEPTH);
  endfunction

  apb_state_e        state_q;
  logic [WAIT_W-1:0] cnt_q;
  logic [WAIT_W-1:0] cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pready_q;
  logic              pslverr_q;
`ifdef APB_SLV_PSTRB_EN
  logic [STRB_W-1:0] strb_q;
`endif

  logic              access_ok;
  logic              last_wait;
  logic              mem_we;
  logic [STRB_W-1:0] mem_be;
  logic [DATA_W-1:0] mem_rdata;

  assign access_ok = psel && pen;
  assign cnt_d     = cnt_q - WAIT_W'(1);
  assign last_wait = (cnt_q == WAIT_W'(1));

  // Transfer state machine with registered pready/pslverr.
  // NOTE: every register here uses <= so all of them update from the same
  // pre-edge values; a blocking '=' would let later lines see new values.
  always_ff @(posedge clk or posedge prst) begin
    if (prst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
`ifdef APB_SLV_PSTRB_EN
      strb_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          // pen without a preceding setup phase is ignored.
          if (psel && !pen) begin
            addr_q    <= paddr;
            write_q   <= pwrite;
            wdata_q   <= pwdata;
`ifdef APB_SLV_PSTRB_EN
            strb_q    <= pstrb;
`endif
            cnt_q     <= WAIT_INIT;
            pready_q  <= (WAIT_INIT == '0);
            pslverr_q <= (WAIT_INIT == '0) && out_of_range(paddr);
            state_q   <= SETUP;
          end
        end
        SETUP, ACCESS: begin
          if (!access_ok || cnt_q == '0) begin
            // Either the transfer completed this cycle or the requester
            // abandoned it; both end in IDLE.
            cnt_q     <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            state_q   <= IDLE;
          end else begin
            cnt_q     <= cnt_d;
            pready_q  <= last_wait;
            pslverr_q <= last_wait && out_of_range(addr_q);
            state_q   <= ACCESS;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // The write lands only if the requester still holds the access phase in
  // the pready cycle and the address is in range.
  assign mem_we = pready_q && access_ok && write_q && !pslverr_q;

`ifdef APB_SLV_PSTRB_EN
  assign mem_be = strb_q;
`else
  assign mem_be = '1;
`endif

  apb_slv_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (mem_be),
    .addr_i  (addr_q[MEM_AW-1:0]),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  assign prdata  = (pready_q && !write_q && !pslverr_q) ? mem_rdata : '0;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Directed bench for apb_mem_slave. Instance 0: WAIT_CYCLES=0, DEPTH=512.
// Instance 1: WAIT_CYCLES=3, DEPTH=256. Each has its own bus signals.
module tb_apb_mem_slave;

  localparam int W0 = 0;
  localparam int W1 = 3;
  localparam int CYC0 = 2 + W0;
  localparam int CYC1 = 2 + W1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        prst;
  logic        psel    [2];
  logic        pen     [2];
  logic        pwrite  [2];
  logic [8:0]  paddr   [2];
  logic [31:0] pwdata  [2];
  logic [31:0] prdata  [2];
  logic        pready  [2];
  logic        pslverr [2];
`ifdef APB_SLV_PSTRB_EN
  logic [3:0]  pstrb   [2];
  logic [3:0]  strb_drv;
`endif

  int checks   = 0;
  int failures = 0;

  apb_mem_slave #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .prst(prst), .psel(psel[0]), .pen(pen[0]), .pwrite(pwrite[0]),
    .paddr(paddr[0]), .pwdata(pwdata[0]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb[0]),
`endif
    .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
  );

  apb_mem_slave #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .prst(prst), .psel(psel[1]), .pen(pen[1]), .pwrite(pwrite[1]),
    .paddr(paddr[1]), .pwdata(pwdata[1]),
`ifdef APB_SLV_PSTRB_EN
    .pstrb(pstrb[1]),
`endif
    .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
  );

  task automatic bus_idle(input int k);
    psel[k] = 1'b0;
    pen[k]  = 1'b0;
  endtask

  // One complete transfer starting at the next rising edge. cycles counts
  // from the setup cycle to the pready cycle inclusive (-1 on timeout);
  // early_nz flags pready/prdata activity before the completing cycle.
  task automatic xfer(input int k, input logic wr, input logic [8:0] addr,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic err, output int cycles, output logic early_nz);
    bit done;
    done = 0;
    rd = '0;
    err = 1'b0;
    early_nz = 1'b0;
    @(posedge clk); #1;
    psel[k] = 1'b1; pen[k] = 1'b0; pwrite[k] = wr; paddr[k] = addr; pwdata[k] = wd;
`ifdef APB_SLV_PSTRB_EN
    pstrb[k] = strb_drv;
`endif
    cycles = 1;
    @(negedge clk);
    if (pready[k] !== 1'b0 || prdata[k] !== 32'h0) early_nz = 1'b1;
    @(posedge clk); #1;
    pen[k] = 1'b1;
    cycles = 2;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (pready[k] === 1'b1) begin
        rd = prdata[k];
        err = pslverr[k];
        done = 1;
      end else begin
        if (prdata[k] !== 32'h0) early_nz = 1'b1;
        @(posedge clk); #1;
        cycles++;
      end
    end
    if (!done) cycles = -1;
  endtask

  task automatic test_reset();
    prst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bus_idle(k);
      pwrite[k] = 1'b0; paddr[k] = '0; pwdata[k] = '0;
`ifdef APB_SLV_PSTRB_EN
      pstrb[k] = 4'hF;
`endif
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (pready[k] !== 1'b0) begin failures++; $display("FAIL reset_pready dut%0d: got %b want 0", k, pready[k]); end
      checks++;
      if (pslverr[k] !== 1'b0) begin failures++; $display("FAIL reset_pslverr dut%0d: got %b want 0", k, pslverr[k]); end
      checks++;
      if (prdata[k] !== 32'h0) begin failures++; $display("FAIL reset_prdata dut%0d: got %h want 0", k, prdata[k]); end
    end
    @(posedge clk); #1;
    prst = 1'b0;
  endtask

  task automatic test_wait0();
    logic [31:0] rd; logic err, enz; int cyc;
    xfer(0, 1'b1, 9'd5, 32'hDEADBEEF, rd, err, cyc, enz);
    checks++;
    if (cyc !== CYC0) begin failures++; $display("FAIL w0_wr_cycles: got %0d want %0d", cyc, CYC0); end
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL w0_wr_err: got %b want 0", err); end
    xfer(0, 1'b0, 9'd5, 32'h0, rd, err, cyc, enz);
    checks++;
    if (cyc !== CYC0) begin failures++; $display("FAIL w0_rd_cycles: got %0d want %0d", cyc, CYC0); end
    checks++;
    if (rd !== 32'hDEADBEEF) begin failures++; $display("FAIL w0_rd_data: got %h want deadbeef", rd); end
    checks++;
    if (err !== 1'b0 || enz !== 1'b0) begin failures++; $display("FAIL w0_rd_err_early: got err=%b early=%b want 0 0", err, enz); end
    @(posedge clk); #1; bus_idle(0);
    @(negedge clk);
    checks++;
    if (prdata[0] !== 32'h0) begin failures++; $display("FAIL w0_prdata_after: got %h want 0", prdata[0]); end
  endtask

  task automatic test_wait3();
    logic [31:0] rd; logic err, enz; int cyc;
    xfer(1, 1'b1, 9'd7, 32'h11, rd, err, cyc, enz);
    checks++;
    if (cyc !== CYC1) begin failures++; $display("FAIL w3_wr_cycles: got %0d want %0d", cyc, CYC1); end
    xfer(1, 1'b0, 9'd7, 32'h0, rd, err, cyc, enz);
    checks++;
    if (cyc !== CYC1) begin failures++; $display("FAIL w3_rd_cycles: got %0d want %0d", cyc, CYC1); end
    checks++;
    if (rd !== 32'h11) begin failures++; $display("FAIL w3_rd_data: got %h want 11", rd); end
    checks++;
    if (enz !== 1'b0) begin failures++; $display("FAIL w3_rd_early: prdata/pready active before completion"); end
    @(posedge clk); #1; bus_idle(1);
    @(negedge clk);
    checks++;
    if (prdata[1] !== 32'h0 || pready[1] !== 1'b0) begin failures++; $display("FAIL w3_after: got prdata=%h pready=%b want 0 0", prdata[1], pready[1]); end
  endtask

  task automatic test_error();
    logic [31:0] rd; logic err, enz; int cyc;
    xfer(1, 1'b1, 9'd44, 32'h44, rd, err, cyc, enz);
    xfer(1, 1'b1, 9'd300, 32'hAA, rd, err, cyc, enz);
    checks++;
    if (err !== 1'b1 || cyc !== CYC1) begin failures++; $display("FAIL err_wr300: got err=%b cyc=%0d want 1 %0d", err, cyc, CYC1); end
    xfer(1, 1'b0, 9'd300, 32'h0, rd, err, cyc, enz);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_rd300_err: got %b want 1", err); end
    checks++;
    if (rd !== 32'h0) begin failures++; $display("FAIL err_rd300_data: got %h want 0", rd); end
    xfer(1, 1'b0, 9'd44, 32'h0, rd, err, cyc, enz);
    checks++;
    if (rd !== 32'h44 || err !== 1'b0) begin failures++; $display("FAIL err_alias44: got %h err=%b want 44 0", rd, err); end
    xfer(1, 1'b1, 9'd255, 32'hC3, rd, err, cyc, enz);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL err_wr255: got err=%b want 0", err); end
    xfer(1, 1'b1, 9'd256, 32'h3C, rd, err, cyc, enz);
    checks++;
    if (err !== 1'b1) begin failures++; $display("FAIL err_wr256: got err=%b want 1", err); end
    xfer(1, 1'b0, 9'd255, 32'h0, rd, err, cyc, enz);
    checks++;
    if (rd !== 32'hC3 || err !== 1'b0) begin failures++; $display("FAIL err_rd255: got %h err=%b want c3 0", rd, err); end
    @(posedge clk); #1; bus_idle(1);
  endtask

  task automatic test_latch();
    logic [31:0] rd; logic err, enz; int cyc;
    xfer(0, 1'b1, 9'd11, 32'h0000C0DE, rd, err, cyc, enz);
    @(posedge clk); #1;
    psel[0] = 1'b1; pen[0] = 1'b0; pwrite[0] = 1'b1; paddr[0] = 9'd10; pwdata[0] = 32'h1234ABCD;
    @(posedge clk); #1;
    pen[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 9'd11; pwdata[0] = 32'h00000BAD;
    @(negedge clk);
    checks++;
    if (pready[0] !== 1'b1 || pslverr[0] !== 1'b0) begin failures++; $display("FAIL latch_ready: got pready=%b pslverr=%b want 1 0", pready[0], pslverr[0]); end
    xfer(0, 1'b0, 9'd10, 32'h0, rd, err, cyc, enz);
    checks++;
    if (rd !== 32'h1234ABCD) begin failures++; $display("FAIL latch_rd10: got %h want 1234abcd", rd); end
    xfer(0, 1'b0, 9'd11, 32'h0, rd, err, cyc, enz);
    checks++;
    if (rd !== 32'h0000C0DE) begin failures++; $display("FAIL latch_rd11: got %h want c0de", rd); end
    @(posedge clk); #1; bus_idle(0);
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic err, enz; int cyc;
    logic seen;
    xfer(1, 1'b1, 9'd2, 32'h77, rd, err, cyc, enz);
    // Drop psel in the third access cycle, one cycle before pready would rise.
    seen = 1'b0;
    @(posedge clk); #1;
    psel[1] = 1'b1; pen[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'd2; pwdata[1] = 32'h55;
    @(posedge clk); #1; pen[1] = 1'b1;
    @(negedge clk); seen |= pready[1];
    @(posedge clk); #1;
    @(negedge clk); seen |= pready[1];
    @(posedge clk); #1; bus_idle(1);
    for (int n = 0; n < 8; n++) begin @(negedge clk); seen |= pready[1]; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_psel_pready: got %b want 0", seen); end
    xfer(1, 1'b0, 9'd2, 32'h0, rd, err, cyc, enz);
    checks++;
    if (rd !== 32'h77) begin failures++; $display("FAIL abort_psel_data: got %h want 77", rd); end
    // Reset in the middle of the access phase.
    seen = 1'b0;
    @(posedge clk); #1;
    psel[1] = 1'b1; pen[1] = 1'b0; pwrite[1] = 1'b1; paddr[1] = 9'd2; pwdata[1] = 32'h55;
    @(posedge clk); #1; pen[1] = 1'b1;
    @(negedge clk); seen |= pready[1];
    @(posedge clk); #1;
    prst = 1'b1; bus_idle(0); bus_idle(1);
    @(negedge clk); seen |= pready[1];
    @(posedge clk); #1; prst = 1'b0;
    for (int n = 0; n < 6; n++) begin @(negedge clk); seen |= pready[1]; end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL abort_rst_pready: got %b want 0", seen); end
    xfer(1, 1'b0, 9'd2, 32'h0, rd, err, cyc, enz);
    checks++;
    if (rd !== 32'h77) begin failures++; $display("FAIL abort_rst_data: got %h want 77", rd); end
    @(posedge clk); #1; bus_idle(1);
  endtask

`ifdef APB_SLV_PSTRB_EN
  task automatic test_strobe();
    logic [31:0] rd; logic err, enz; int cyc;
    strb_drv = 4'hF;
    xfer(0, 1'b1, 9'd20, 32'hFFFFFFFF, rd, err, cyc, enz);
    strb_drv = 4'b0101;
    xfer(0, 1'b1, 9'd20, 32'h12345678, rd, err, cyc, enz);
    strb_drv = 4'b0000;
    xfer(0, 1'b1, 9'd20, 32'h00000000, rd, err, cyc, enz);
    checks++;
    if (err !== 1'b0) begin failures++; $display("FAIL strb_zero_err: got %b want 0", err); end
    strb_drv = 4'b0000;
    xfer(0, 1'b0, 9'd20, 32'h0, rd, err, cyc, enz);
    checks++;
    if (rd !== 32'hFF34FF78) begin failures++; $display("FAIL strb_rd: got %h want ff34ff78", rd); end
    strb_drv = 4'hF;
    @(posedge clk); #1; bus_idle(0);
  endtask
`endif

  task automatic test_back_to_back();
    logic [31:0] rd; logic err, enz; int cyc;
    logic [31:0] exp_d;
    int exp_cyc;
    for (int k = 0; k < 2; k++) begin
      exp_cyc = (k == 0) ? CYC0 : CYC1;
      for (int i = 0; i < 8; i++) begin
        exp_d = 32'h10000000 + 32'(i) * 32'h01020304;
        xfer(k, 1'b1, 9'(32 + i), exp_d, rd, err, cyc, enz);
        checks++;
        if (cyc !== exp_cyc || err !== 1'b0) begin failures++; $display("FAIL b2b_wr dut%0d i%0d: got cyc=%0d err=%b want %0d 0", k, i, cyc, err, exp_cyc); end
      end
      for (int i = 0; i < 8; i++) begin
        exp_d = 32'h10000000 + 32'(i) * 32'h01020304;
        xfer(k, 1'b0, 9'(32 + i), 32'h0, rd, err, cyc, enz);
        checks++;
        if (cyc !== exp_cyc) begin failures++; $display("FAIL b2b_rd_cycles dut%0d i%0d: got %0d want %0d", k, i, cyc, exp_cyc); end
        checks++;
        if (rd !== exp_d) begin failures++; $display("FAIL b2b_rd_data dut%0d i%0d: got %h want %h", k, i, rd, exp_d); end
      end
      @(posedge clk); #1; bus_idle(k);
    end
  endtask

  initial begin
`ifdef APB_SLV_PSTRB_EN
    strb_drv = 4'hF;
`endif
    test_reset();
    test_wait0();
    test_wait3();
    test_error();
    test_latch();
    test_abort();
`ifdef APB_SLV_PSTRB_EN
    test_strobe();
`endif
    test_back_to_back();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
